// File: rtl/rs_issue_scheduler.sv
// ALU reservation-station control: per-slot operand wakeup from both CDB channels,
// lowest-index free-slot pick for dispatch and age-matrix oldest-ready issue select.
module rs_issue_scheduler #(
  parameter int RS_SIZE      = 16,
  parameter int RS_IDX_WIDTH = 4,
  parameter int ROB_ID_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic                    alloc_valid,
  input  logic                    alloc_q1_busy,
  input  logic [ROB_ID_WIDTH-1:0] alloc_q1,
  input  logic                    alloc_q2_busy,
  input  logic [ROB_ID_WIDTH-1:0] alloc_q2,
  output logic [RS_IDX_WIDTH-1:0] free_slot,
  output logic                    full,
  input  logic                    cdb_alu_valid,
  input  logic [ROB_ID_WIDTH-1:0] cdb_alu_tag,
  input  logic                    cdb_lsb_valid,
  input  logic [ROB_ID_WIDTH-1:0] cdb_lsb_tag,
  output logic                    issue_valid,
  output logic [RS_IDX_WIDTH-1:0] issue_slot
);

  logic [RS_SIZE-1:0]      busy_r;
  logic [RS_SIZE-1:0]      w1_r;
  logic [RS_SIZE-1:0]      w2_r;
  logic [ROB_ID_WIDTH-1:0] t1_r [RS_SIZE];
  logic [ROB_ID_WIDTH-1:0] t2_r [RS_SIZE];
  // age_r[i][j] = 1 means slot i was allocated before slot j
  logic [RS_SIZE-1:0]      age_r [RS_SIZE];
  logic                    issue_valid_r;
  logic [RS_IDX_WIDTH-1:0] issue_slot_r;

  logic [RS_SIZE-1:0]      age_col_s [RS_SIZE];
  logic [RS_SIZE-1:0]      ready_s;
  logic [RS_SIZE-1:0]      oldest_s;
  logic [RS_IDX_WIDTH-1:0] free_slot_s;
  logic [RS_IDX_WIDTH-1:0] sel_slot_s;
  logic                    any_ready_s;
  logic                    full_s;
  logic                    alloc_fire_s;

  function automatic logic cdb_hit(
    input logic [ROB_ID_WIDTH-1:0] tag,
    input logic                    alu_v,
    input logic [ROB_ID_WIDTH-1:0] alu_t,
    input logic                    lsb_v,
    input logic [ROB_ID_WIDTH-1:0] lsb_t
  );
    return (alu_v && (tag == alu_t)) || (lsb_v && (tag == lsb_t));
  endfunction

  // Transpose the age matrix so each slot sees which slots are older than it
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      age_col_s[i] = '0;
      for (int j = 0; j < RS_SIZE; j++) begin
        age_col_s[i][j] = age_r[j][i];
      end
    end
  end

  // Readiness and oldest-ready filter; any older ready slot blocks a candidate
  always_comb begin
    ready_s  = busy_r & ~w1_r & ~w2_r;
    oldest_s = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      oldest_s[i] = ready_s[i] & ~(|(ready_s & age_col_s[i]));
    end
  end

  // Priority encoders: lowest free slot and lowest oldest-ready slot
  always_comb begin
    free_slot_s = '0;
    sel_slot_s  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      free_slot_s = busy_r[i]   ? free_slot_s : RS_IDX_WIDTH'(i);
      sel_slot_s  = oldest_s[i] ? RS_IDX_WIDTH'(i) : sel_slot_s;
    end
    any_ready_s  = |ready_s;
    full_s       = &busy_r;
    alloc_fire_s = alloc_valid & ~full_s;
  end

  assign free_slot   = free_slot_s;
  assign full        = full_s;
  assign issue_valid = issue_valid_r;
  assign issue_slot  = issue_slot_r;

  // Slot state, age matrix and issue registers; rdy=0 freezes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r        <= '0;
      w1_r          <= '0;
      w2_r          <= '0;
      issue_valid_r <= 1'b0;
      issue_slot_r  <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        t1_r[i]  <= '0;
        t2_r[i]  <= '0;
        age_r[i] <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        busy_r        <= '0;
        issue_valid_r <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (cdb_hit(t1_r[i], cdb_alu_valid, cdb_alu_tag, cdb_lsb_valid, cdb_lsb_tag)) begin
            w1_r[i] <= 1'b0;
          end
          if (cdb_hit(t2_r[i], cdb_alu_valid, cdb_alu_tag, cdb_lsb_valid, cdb_lsb_tag)) begin
            w2_r[i] <= 1'b0;
          end
        end

        if (any_ready_s) begin
          issue_valid_r        <= 1'b1;
          issue_slot_r         <= sel_slot_s;
          busy_r[sel_slot_s]   <= 1'b0;
        end else begin
          issue_valid_r <= 1'b0;
        end

        // The free slot is never busy, so it cannot collide with the issued slot
        if (alloc_fire_s) begin
          busy_r[free_slot_s] <= 1'b1;
          w1_r[free_slot_s]   <= alloc_q1_busy &
            ~cdb_hit(alloc_q1, cdb_alu_valid, cdb_alu_tag, cdb_lsb_valid, cdb_lsb_tag);
          w2_r[free_slot_s]   <= alloc_q2_busy &
            ~cdb_hit(alloc_q2, cdb_alu_valid, cdb_alu_tag, cdb_lsb_valid, cdb_lsb_tag);
          t1_r[free_slot_s]   <= alloc_q1;
          t2_r[free_slot_s]   <= alloc_q2;
          for (int j = 0; j < RS_SIZE; j++) begin
            if (RS_IDX_WIDTH'(j) == free_slot_s) begin
              age_r[j] <= '0;
            end else begin
              age_r[j][free_slot_s] <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Scoreboard bench for rs_issue_scheduler: expected issue slots are queued when
// stimulus is driven and compared as issues appear.
module tb_rs_issue_scheduler;

  logic       clk = 1'b0;
  logic       rst, rdy, flush;
  logic       alloc_valid, alloc_q1_busy, alloc_q2_busy;
  logic [3:0] alloc_q1, alloc_q2;
  logic [3:0] free_slot;
  logic       full;
  logic       cdb_alu_valid, cdb_lsb_valid;
  logic [3:0] cdb_alu_tag, cdb_lsb_tag;
  logic       issue_valid;
  logic [3:0] issue_slot;

  int vectors    = 0;
  int miscompares = 0;
  int exp_q[$];

  rs_issue_scheduler #(.RS_SIZE(16), .RS_IDX_WIDTH(4), .ROB_ID_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_q1_busy(alloc_q1_busy), .alloc_q1(alloc_q1),
    .alloc_q2_busy(alloc_q2_busy), .alloc_q2(alloc_q2),
    .free_slot(free_slot), .full(full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_tag(cdb_alu_tag),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_tag(cdb_lsb_tag),
    .issue_valid(issue_valid), .issue_slot(issue_slot)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    vectors++;
    if (obs !== expd) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expd);
    end
  endtask

  // One clock; new issues (edges taken with rdy=1) are scored against the queue
  task automatic step();
    logic r;
    r = rdy;
    @(posedge clk);
    #1;
    if (r && issue_valid) begin
      check_eq("issue_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check_eq("issue_slot", issue_slot, exp_q.pop_front());
    end
  endtask

  task automatic drive_alloc(input logic v, input logic b1, input logic [3:0] q1,
                             input logic b2, input logic [3:0] q2);
    alloc_valid = v; alloc_q1_busy = b1; alloc_q1 = q1; alloc_q2_busy = b2; alloc_q2 = q2;
  endtask

  task automatic drive_cdb(input logic av, input logic [3:0] at, input logic lv, input logic [3:0] lt);
    cdb_alu_valid = av; cdb_alu_tag = at; cdb_lsb_valid = lv; cdb_lsb_tag = lt;
  endtask

  task automatic idle();
    drive_alloc(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    drive_cdb(1'b0, 4'd0, 1'b0, 4'd0);
    flush = 1'b0;
  endtask

  initial begin
    int exp_free [3];
    exp_free = '{0, 1, 0};
    rst = 1'b1; rdy = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_issue_valid", issue_valid, 0);
    check_eq("rst_issue_slot", issue_slot, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_free_slot", free_slot, 0);
    rst = 1'b0;
    step();

    // Three back-to-back ready allocs; the issued slot 0 is reused by the third
    for (int k = 0; k < 3; k++) begin
      drive_alloc(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
      check_eq("t1_free_slot", free_slot, exp_free[k]);
      exp_q.push_back(exp_free[k]);
      step();
      check_eq("t1_issue_valid", issue_valid, k > 0);
      check_eq("t1_full", full, 0);
    end
    idle();
    step();
    check_eq("t1_issue_valid_last", issue_valid, 1);
    step();
    check_eq("t1_issue_idle", issue_valid, 0);
    check_eq("t1_drain", exp_q.size(), 0);

    // Waiting slot 0 is passed by ready slot 1; woken later by the LSB channel
    drive_alloc(1'b1, 1'b1, 4'd5, 1'b0, 4'd0);
    check_eq("t2_free0", free_slot, 0);
    step();
    drive_alloc(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    check_eq("t2_free1", free_slot, 1);
    exp_q.push_back(1);
    step();
    idle();
    drive_cdb(1'b1, 4'd6, 1'b0, 4'd0);
    step();
    check_eq("t2_issue_slot1", issue_valid, 1);
    idle();
    drive_cdb(1'b0, 4'd0, 1'b1, 4'd5);
    exp_q.push_back(0);
    step();
    check_eq("t2_wake_edge_no_issue", issue_valid, 0);
    idle();
    step();
    check_eq("t2_issue_slot0", issue_valid, 1);
    step();
    check_eq("t2_idle", issue_valid, 0);
    check_eq("t2_drain", exp_q.size(), 0);

    // Same-cycle CDB bypass on both operands, both channels
    drive_alloc(1'b1, 1'b1, 4'd3, 1'b1, 4'd7);
    drive_cdb(1'b1, 4'd3, 1'b1, 4'd7);
    check_eq("t3_free0", free_slot, 0);
    exp_q.push_back(0);
    step();
    check_eq("t3_alloc_edge", issue_valid, 0);
    idle();
    step();
    check_eq("t3_bypass_issue", issue_valid, 1);
    step();
    check_eq("t3_idle", issue_valid, 0);
    check_eq("t3_drain", exp_q.size(), 0);

    // Fill all 16 slots waiting on tag 9, extra alloc ignored, then mass wakeup
    for (int k = 0; k < 16; k++) begin
      drive_alloc(1'b1, 1'b1, 4'd9, 1'b0, 4'd0);
      check_eq("t4_free_slot", free_slot, k);
      check_eq("t4_not_full", full, 0);
      step();
    end
    check_eq("t4_full", full, 1);
    drive_alloc(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    step();
    check_eq("t4_full_after_extra", full, 1);
    check_eq("t4_no_issue_extra", issue_valid, 0);
    idle();
    drive_cdb(1'b1, 4'd9, 1'b0, 4'd0);
    for (int k = 0; k < 16; k++) exp_q.push_back(k);
    step();
    check_eq("t4_wake_edge", issue_valid, 0);
    idle();
    for (int k = 0; k < 16; k++) begin
      step();
      check_eq("t4_burst_valid", issue_valid, 1);
    end
    step();
    check_eq("t4_end_valid", issue_valid, 0);
    check_eq("t4_end_full", full, 0);
    check_eq("t4_end_free", free_slot, 0);
    check_eq("t4_drain", exp_q.size(), 0);

    // Age over index: older slot 1 must beat younger slot 0
    drive_alloc(1'b1, 1'b1, 4'd1, 1'b0, 4'd0);
    check_eq("t5_free0", free_slot, 0);
    step();
    drive_alloc(1'b1, 1'b1, 4'd2, 1'b0, 4'd0);
    check_eq("t5_free1", free_slot, 1);
    step();
    idle();
    drive_cdb(1'b1, 4'd1, 1'b0, 4'd0);
    exp_q.push_back(0);
    step();
    idle();
    step();
    check_eq("t5_first_issue", issue_valid, 1);
    drive_alloc(1'b1, 1'b0, 4'd0, 1'b1, 4'd2);
    check_eq("t5_free_reuse", free_slot, 0);
    step();
    idle();
    drive_cdb(1'b0, 4'd0, 1'b1, 4'd2);
    exp_q.push_back(1);
    exp_q.push_back(0);
    step();
    idle();
    step();
    check_eq("t5_older_issue", issue_valid, 1);
    step();
    check_eq("t5_younger_issue", issue_valid, 1);
    step();
    check_eq("t5_idle", issue_valid, 0);
    check_eq("t5_drain", exp_q.size(), 0);

    // rdy=0 freeze with pending ready entry, alloc and CDB traffic
    drive_alloc(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    exp_q.push_back(0);
    step();
    check_eq("t6_free1", free_slot, 1);
    exp_q.push_back(1);
    step();
    rdy = 1'b0;
    drive_alloc(1'b1, 1'b1, 4'd4, 1'b0, 4'd0);
    drive_cdb(1'b1, 4'd4, 1'b1, 4'd4);
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("t6_hold_valid", issue_valid, 1);
      check_eq("t6_hold_slot", issue_slot, 0);
      check_eq("t6_hold_free", free_slot, 0);
      check_eq("t6_hold_full", full, 0);
    end
    rdy = 1'b1;
    idle();
    step();
    check_eq("t6_resume_valid", issue_valid, 1);
    check_eq("t6_resume_slot", issue_slot, 1);
    step();
    check_eq("t6_idle", issue_valid, 0);
    check_eq("t6_empty_free", free_slot, 0);
    check_eq("t6_drain", exp_q.size(), 0);

    // Flush with 5 busy slots (one ready) and a concurrent alloc
    for (int k = 0; k < 4; k++) begin
      drive_alloc(1'b1, 1'b1, 4'd10, 1'b0, 4'd0);
      step();
    end
    drive_alloc(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    check_eq("t7_free4", free_slot, 4);
    step();
    flush = 1'b1;
    step();
    check_eq("t7_flush_valid", issue_valid, 0);
    check_eq("t7_flush_full", full, 0);
    check_eq("t7_flush_free", free_slot, 0);
    idle();
    drive_cdb(1'b1, 4'd10, 1'b0, 4'd0);
    step();
    idle();
    step();
    check_eq("t7_no_entries", issue_valid, 0);
    check_eq("t7_free_after", free_slot, 0);
    check_eq("t7_drain", exp_q.size(), 0);

    // Asynchronous reset in the middle of an issue burst
    drive_alloc(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    exp_q.push_back(0);
    step();
    exp_q.push_back(1);
    step();
    check_eq("t8_burst_valid", issue_valid, 1);
    #3 rst = 1'b1;
    #1;
    check_eq("t8_async_valid", issue_valid, 0);
    check_eq("t8_async_slot", issue_slot, 0);
    check_eq("t8_async_full", full, 0);
    check_eq("t8_async_free", free_slot, 0);
    exp_q.delete();
    idle();
    step();
    rst = 1'b0;
    step();
    check_eq("t8_post_reset", issue_valid, 0);
    check_eq("t8_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
